// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// maze_pkg : constants and encodings shared by the maze RNG and carver | rev 1.0
// ============================================================================
package maze_pkg;

  localparam int          LFSR_WIDTH   = 16;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  // Taps 15,13,12,10: x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] TAP_MASK     = 16'hB400;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_shift(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], ^(s & TAP_MASK)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rand_num_gen_if.sv
`default_nettype none
// ============================================================================
// rand_num_gen_if : control and output bundle of the maze RNG | rev 1.0
// ============================================================================
interface rand_num_gen_if #(
  parameter int OUT_WIDTH = 2
);

  logic                 en_i;
  logic                 seed_load_i;
  logic [15:0]          seed_i;
  logic [OUT_WIDTH-1:0] rand_o;
  logic [15:0]          state_o;

  modport master (
    output en_i,
    output seed_load_i,
    output seed_i,
    input  rand_o,
    input  state_o
  );

  modport slave (
    input  en_i,
    input  seed_load_i,
    input  seed_i,
    output rand_o,
    output state_o
  );

endinterface
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ============================================================================
// lfsr_step : one combinational Fibonacci LFSR shift | rev 1.0
// ============================================================================
module lfsr_step
  import maze_pkg::*;
(
  input  wire logic [LFSR_WIDTH-1:0] s_i,
  output logic      [LFSR_WIDTH-1:0] s_o
);

  assign s_o = lfsr_shift(s_i);

endmodule
`default_nettype wire

// File: rtl/rand_num_gen.sv
`default_nettype none
// ============================================================================
// rand_num_gen : reseedable 16-bit LFSR direction source, STEP shifts per clock | rev 1.0
// ============================================================================
module rand_num_gen #(
  parameter int                          LFSR_WIDTH = 16,
  parameter int                          OUT_WIDTH  = 2,
  parameter int                          STEP       = 2,
  parameter logic [LFSR_WIDTH-1:0]       SEED       = maze_pkg::DEFAULT_SEED
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  rand_num_gen_if.slave       bus
);

  import maze_pkg::*;

  generate
    if (LFSR_WIDTH != maze_pkg::LFSR_WIDTH) begin : g_bad_width
      $error("rand_num_gen: tap set is only defined for a 16-bit LFSR");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > LFSR_WIDTH) begin : g_bad_out
      $error("rand_num_gen: OUT_WIDTH out of range");
    end
    if (STEP < 1 || STEP > LFSR_WIDTH) begin : g_bad_step
      $error("rand_num_gen: STEP out of range");
    end
  endgenerate

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_d;
  logic [LFSR_WIDTH-1:0] advanced;

  // Each stage owns its input/output so the chain stays acyclic per signal.
  generate
    for (genvar i = 0; i < STEP; i++) begin : g_step
      logic [LFSR_WIDTH-1:0] s_in;
      logic [LFSR_WIDTH-1:0] s_out;
      if (i == 0) begin : g_first
        assign s_in = state_q;
      end else begin : g_next
        assign s_in = g_step[i-1].s_out;
      end
      lfsr_step u_step (
        .s_i (s_in),
        .s_o (s_out)
      );
    end
  endgenerate

  assign advanced = g_step[STEP-1].s_out;

  always_comb begin
    state_d = state_q;
    if (bus.seed_load_i) begin
      state_d = (bus.seed_i == '0) ? SEED : bus.seed_i;
    end else if (bus.en_i) begin
      // All-zero is a lock-up state of the LFSR; recover to the seed.
      state_d = (state_q == '0) ? SEED : advanced;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.state_o = state_q;
  assign bus.rand_o  = state_q[OUT_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_rand_num_gen.sv
`default_nettype none
// ============================================================================
// tb_rand_num_gen : scoreboard bench for rand_num_gen (STEP=2/OUT=2 and STEP=1/OUT=4) | rev 1.0
// ============================================================================
module tb_rand_num_gen;

  localparam logic [15:0] SEED_C = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n;

  rand_num_gen_if #(.OUT_WIDTH(2)) bus0 ();
  rand_num_gen_if #(.OUT_WIDTH(4)) bus1 ();

  rand_num_gen #(.OUT_WIDTH(2), .STEP(2)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  rand_num_gen #(.OUT_WIDTH(4), .STEP(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] m0, m1;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [15:0] ref_next(input logic [15:0] s, input logic sl,
                                           input logic en, input logic [15:0] sd,
                                           input int step);
    logic [15:0] r;
    if (sl) return (sd == 16'h0) ? SEED_C : sd;
    if (!en) return s;
    if (s == 16'h0) return SEED_C;
    r = s;
    for (int k = 0; k < step; k++) r = ref_shift(r);
    return r;
  endfunction

  task automatic pop_check(input bit verbose);
    logic [15:0] e0, e1;
    if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e0 = exp_q0.pop_front();
    e1 = exp_q1.pop_front();
    if (verbose || bus0.state_o !== e0 || bus1.state_o !== e1) begin
      chk("state0", {16'h0, bus0.state_o}, {16'h0, e0});
      chk("rand0",  {30'h0, bus0.rand_o},  {30'h0, e0[1:0]});
      chk("state1", {16'h0, bus1.state_o}, {16'h0, e1});
      chk("rand1",  {28'h0, bus1.rand_o},  {28'h0, e1[3:0]});
    end else begin
      n_chk += 4;
    end
  endtask

  task automatic step(input logic en, input logic sl, input logic [15:0] sd, input bit verbose);
    bus0.en_i = en; bus0.seed_load_i = sl; bus0.seed_i = sd;
    bus1.en_i = en; bus1.seed_load_i = sl; bus1.seed_i = sd;
    m0 = ref_next(m0, sl, en, sd, 2);
    m1 = ref_next(m1, sl, en, sd, 1);
    exp_q0.push_back(m0);
    exp_q1.push_back(m1);
    @(posedge clk);
    #1;
    pop_check(verbose);
  endtask

  // Asynchronous pulse placed between edges; outputs must react before the next edge.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_state0"}, {16'h0, bus0.state_o}, {16'h0, SEED_C});
    chk({tag, "_state1"}, {16'h0, bus1.state_o}, {16'h0, SEED_C});
    #1 rst_n = 1'b1;
    m0 = SEED_C;
    m1 = SEED_C;
  endtask

  int          first0, first1, zero_seen;
  int          hist[4];
  logic [15:0] exp_first;

  initial begin
    rst_n = 1'b0;
    bus0.en_i = 1'b1; bus0.seed_load_i = 1'b0; bus0.seed_i = 16'h0;
    bus1.en_i = 1'b1; bus1.seed_load_i = 1'b0; bus1.seed_i = 16'h0;
    m0 = SEED_C;
    m1 = SEED_C;

    // Reset held with en=1
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state0", {16'h0, bus0.state_o}, 32'h0000ACE1);
    chk("rst_rand0",  {30'h0, bus0.rand_o},  32'h1);
    chk("rst_rand1",  {28'h0, bus1.rand_o},  32'h1);
    rst_n = 1'b1;

    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("first_state0", {16'h0, bus0.state_o}, 32'h0000B387);
    chk("first_rand0",  {30'h0, bus0.rand_o},  32'h3);
    chk("first_state1", {16'h0, bus1.state_o}, 32'h000059C3);
    chk("first_rand1",  {28'h0, bus1.rand_o},  32'h3);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("second_state0", {16'h0, bus0.state_o}, 32'h0000CE1E);
    chk("second_rand0",  {30'h0, bus0.rand_o},  32'h2);

    // Enable hold
    pulse_reset("hold_rst");
    repeat (5) step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("hold_state0", {16'h0, bus0.state_o}, 32'h0000ACE1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("resume_state0", {16'h0, bus0.state_o}, 32'h0000B387);

    // Reseed, including zero-seed substitution and seed_load winning over en
    step(1'b1, 1'b1, 16'h1234, 1'b1);
    chk("reseed_state0", {16'h0, bus0.state_o}, 32'h00001234);
    chk("reseed_rand0",  {30'h0, bus0.rand_o},  32'h0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    chk("zero_seed_state0", {16'h0, bus0.state_o}, 32'h0000ACE1);
    step(1'b1, 1'b1, 16'hFFFF, 1'b1);
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Async reset mid-run
    repeat (100) step(1'b1, 1'b0, 16'h0, 1'b0);
    pulse_reset("mid_rst");
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("mid_after_state0", {16'h0, bus0.state_o}, 32'h0000B387);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("mid_after2_state0", {16'h0, bus0.state_o}, 32'h0000CE1E);

    // Full period and distribution
    pulse_reset("period_rst");
    first0 = 0; first1 = 0; zero_seen = 0;
    for (int h = 0; h < 4; h++) hist[h] = 0;
    for (int i = 1; i <= 65535; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      if (bus0.state_o == SEED_C && first0 == 0) first0 = i;
      if (bus1.state_o == SEED_C && first1 == 0) first1 = i;
      if (bus0.state_o == 16'h0 || bus1.state_o == 16'h0) zero_seen++;
      hist[bus0.rand_o]++;
    end
    chk("period0",    first0,    32'd65535);
    chk("period1",    first1,    32'd65535);
    chk("zero_state", zero_seen, 32'd0);
    chk("hist_00",    hist[0],   32'd16383);
    chk("hist_01",    hist[1],   32'd16384);
    chk("hist_10",    hist[2],   32'd16384);
    chk("hist_11",    hist[3],   32'd16384);
    exp_first = 16'hB387;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("wrap_state0", {16'h0, bus0.state_o}, {16'h0, exp_first});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
